// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded operands and controls for EX, generates
// operand forwarding selects and a combinational load-use stall request back to ID.
module id_ex_stage #(
  parameter int WIDTH = 8,
  parameter int RW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [RW-1:0]    rs_a,
  input  logic [RW-1:0]    rs_b,
  input  logic [RW-1:0]    rd,
  input  logic [WIDTH-1:0] ra_data,
  input  logic [WIDTH-1:0] rb_data,
  input  logic [WIDTH-1:0] imm,
  input  logic [3:0]       alu_op,
  input  logic             use_imm,
  input  logic             reg_we,
  input  logic             mem_rd,
  input  logic             mem_wr,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] imm_q,
  output logic             b_sel,
  output logic             fwd_a_sel,
  output logic             fwd_b_sel,
  output logic [RW-1:0]    rd_q,
  output logic [3:0]       alu_op_q,
  output logic             reg_we_q,
  output logic             mem_rd_q,
  output logic             mem_wr_q,
  output logic             out_valid,
  output logic             load_use_hazard
);

  logic match_a;
  logic match_b;
  logic fwd_a_nxt;
  logic fwd_b_nxt;
  logic bubble;

  // Dependency detection against the instruction currently held in the stage.
  // A bubble has out_valid=0, so it can never raise a hazard or a forward.
  assign match_a         = (rd_q == rs_a);
  assign match_b         = (rd_q == rs_b);
  assign load_use_hazard = in_valid & out_valid & mem_rd_q & (match_a | (~use_imm & match_b));
  assign fwd_a_nxt       = in_valid & out_valid & reg_we_q & match_a;
  assign fwd_b_nxt       = in_valid & ~use_imm & out_valid & reg_we_q & match_b;
  assign bubble          = flush | (~stall & load_use_hazard);

  // ID -> EX boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      alu_op_q  <= '0;
      b_sel     <= 1'b0;
      fwd_a_sel <= 1'b0;
      fwd_b_sel <= 1'b0;
      reg_we_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      out_valid <= 1'b0;
    end else if (bubble) begin
      b_sel     <= 1'b0;
      fwd_a_sel <= 1'b0;
      fwd_b_sel <= 1'b0;
      reg_we_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      a_q       <= ra_data;
      b_q       <= rb_data;
      imm_q     <= imm;
      rd_q      <= rd;
      alu_op_q  <= alu_op;
      b_sel     <= use_imm;
      fwd_a_sel <= fwd_a_nxt;
      fwd_b_sel <= fwd_b_nxt;
      reg_we_q  <= in_valid & reg_we;
      mem_rd_q  <= in_valid & mem_rd;
      // A read wins over a conflicting write so both are never issued together.
      mem_wr_q  <= in_valid & mem_wr & ~mem_rd;
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts the stage contents each
// cycle; predictions and sampled outputs are queued and compared by each scenario task.
module tb_id_ex_stage;

  localparam int WIDTH = 8;
  localparam int RW    = 2;

  logic clk, rst_n, stall, flush, in_valid;
  logic [RW-1:0] rs_a, rs_b, rd;
  logic [WIDTH-1:0] ra_data, rb_data, imm;
  logic [3:0] alu_op;
  logic use_imm, reg_we, mem_rd, mem_wr;
  logic [WIDTH-1:0] a_q, b_q, imm_q;
  logic b_sel, fwd_a_sel, fwd_b_sel;
  logic [RW-1:0] rd_q;
  logic [3:0] alu_op_q;
  logic reg_we_q, mem_rd_q, mem_wr_q, out_valid, load_use_hazard;

  typedef struct packed {
    logic             out_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] imm;
    logic             b_sel;
    logic             fwd_a;
    logic             fwd_b;
    logic [RW-1:0]    rd;
    logic [3:0]       alu_op;
    logic             reg_we;
    logic             mem_rd;
    logic             mem_wr;
  } out_t;

  out_t m;
  out_t exp_q[$];
  out_t got_q[$];
  int checks = 0;
  int failures = 0;

  id_ex_stage #(.WIDTH(WIDTH), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .rs_a(rs_a), .rs_b(rs_b), .rd(rd), .ra_data(ra_data), .rb_data(rb_data), .imm(imm),
    .alu_op(alu_op), .use_imm(use_imm), .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .a_q(a_q), .b_q(b_q), .imm_q(imm_q), .b_sel(b_sel), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .rd_q(rd_q), .alu_op_q(alu_op_q), .reg_we_q(reg_we_q),
    .mem_rd_q(mem_rd_q), .mem_wr_q(mem_wr_q), .out_valid(out_valid),
    .load_use_hazard(load_use_hazard)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic out_t sample();
    out_t s;
    s.out_valid = out_valid; s.a = a_q; s.b = b_q; s.imm = imm_q;
    s.b_sel = b_sel; s.fwd_a = fwd_a_sel; s.fwd_b = fwd_b_sel; s.rd = rd_q;
    s.alu_op = alu_op_q; s.reg_we = reg_we_q; s.mem_rd = mem_rd_q; s.mem_wr = mem_wr_q;
    return s;
  endfunction

  // Fields a bubble is allowed to leave stale are cleared before comparing bubbles.
  function automatic out_t strip(out_t s);
    out_t r = s;
    r.a = '0; r.b = '0; r.imm = '0; r.rd = '0; r.alu_op = '0;
    return r;
  endfunction

  function automatic logic model_hz(out_t s);
    return in_valid & s.out_valid & s.mem_rd &
           ((s.rd == rs_a) | (!use_imm & (s.rd == rs_b)));
  endfunction

  function automatic out_t model_next(out_t s);
    out_t n = s;
    if (flush || (!stall && model_hz(s))) begin
      n.out_valid = 0; n.reg_we = 0; n.mem_rd = 0; n.mem_wr = 0;
      n.b_sel = 0; n.fwd_a = 0; n.fwd_b = 0;
    end else if (!stall) begin
      n.out_valid = in_valid;
      n.a = ra_data; n.b = rb_data; n.imm = imm; n.rd = rd; n.alu_op = alu_op;
      n.b_sel  = use_imm;
      n.reg_we = in_valid & reg_we;
      n.mem_rd = in_valid & mem_rd;
      n.mem_wr = in_valid & mem_wr & !mem_rd;
      n.fwd_a  = in_valid & s.out_valid & s.reg_we & (s.rd == rs_a);
      n.fwd_b  = in_valid & !use_imm & s.out_valid & s.reg_we & (s.rd == rs_b);
    end
    return n;
  endfunction

  task automatic set_instr(input logic v, input logic [RW-1:0] sa, input logic [RW-1:0] sb,
                           input logic [RW-1:0] d, input logic [WIDTH-1:0] ra,
                           input logic [WIDTH-1:0] rb, input logic [WIDTH-1:0] im,
                           input logic [3:0] op, input logic ui, input logic we,
                           input logic mr, input logic mw);
    in_valid = v; rs_a = sa; rs_b = sb; rd = d; ra_data = ra; rb_data = rb; imm = im;
    alu_op = op; use_imm = ui; reg_we = we; mem_rd = mr; mem_wr = mw;
  endtask

  task automatic step();
    out_t e;
    e = model_next(m);
    m = e;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got_q.push_back(sample());
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 0; flush = 0;
    set_instr(1, 1, 2, 3, 8'h55, 8'h66, 8'h77, 4'h3, 0, 1, 1, 0);
    #12;
    checks++;
    if (sample() !== '0) begin failures++; $display("FAIL reset_outputs: got %h required 0", sample()); end
    checks++;
    if (load_use_hazard !== 1'b0) begin failures++; $display("FAIL reset_hazard: got %b required 0", load_use_hazard); end
    @(posedge clk); #1;
    checks++;
    if (sample() !== '0) begin failures++; $display("FAIL reset_no_capture: got %h required 0", sample()); end
    rst_n = 1'b1;
    m = '0;
  endtask

  task automatic test_add();
    set_instr(1, 1, 2, 3, 8'h12, 8'h34, 8'h00, 4'h0, 0, 1, 0, 0);
    step();
    checks++;
    if ({out_valid, a_q, b_q, b_sel, fwd_a_sel, fwd_b_sel} !== {1'b1, 8'h12, 8'h34, 3'b000}) begin
      failures++;
      $display("FAIL add_first_load: got v=%b a=%h b=%h bsel=%b fa=%b fb=%b required v=1 a=12 b=34 bsel=0 fa=0 fb=0",
               out_valid, a_q, b_q, b_sel, fwd_a_sel, fwd_b_sel);
    end
    while (exp_q.size() > 0) begin
      out_t e = exp_q.pop_front();
      out_t g = got_q.pop_front();
      checks++;
      if (e.out_valid ? (g !== e) : (strip(g) !== strip(e))) begin
        failures++; $display("FAIL add_sb: got %h required %h", g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    set_instr(1, 0, 1, 2, 8'h01, 8'h02, 8'h03, 4'h1, 0, 1, 0, 0);
    step();
    set_instr(1, 2, 2, 2, 8'h11, 8'h22, 8'h33, 4'h2, 1, 1, 0, 0);
    step();
    checks++;
    if ({fwd_a_sel, fwd_b_sel, b_sel} !== 3'b101) begin
      failures++; $display("FAIL b2b_fwd_imm: got fa=%b fb=%b bsel=%b required fa=1 fb=0 bsel=1", fwd_a_sel, fwd_b_sel, b_sel);
    end
    set_instr(1, 3, 2, 1, 8'h44, 8'h55, 8'h66, 4'h3, 0, 0, 0, 0);
    step();
    checks++;
    if ({fwd_a_sel, fwd_b_sel, b_sel} !== 3'b010) begin
      failures++; $display("FAIL b2b_fwd_b: got fa=%b fb=%b bsel=%b required fa=0 fb=1 bsel=0", fwd_a_sel, fwd_b_sel, b_sel);
    end
    set_instr(1, 1, 1, 0, 8'h77, 8'h88, 8'h99, 4'h4, 0, 0, 0, 0);
    step();
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 2'b00) begin
      failures++; $display("FAIL b2b_no_we: got fa=%b fb=%b required fa=0 fb=0", fwd_a_sel, fwd_b_sel);
    end
    while (exp_q.size() > 0) begin
      out_t e = exp_q.pop_front();
      out_t g = got_q.pop_front();
      checks++;
      if (e.out_valid ? (g !== e) : (strip(g) !== strip(e))) begin
        failures++; $display("FAIL b2b_sb: got %h required %h", g, e);
      end
    end
  endtask

  task automatic test_load_use();
    set_instr(1, 0, 0, 1, 8'hA0, 8'hB0, 8'h04, 4'h5, 1, 1, 1, 0);
    step();
    set_instr(1, 0, 1, 0, 8'hC0, 8'hD0, 8'h00, 4'h6, 0, 1, 0, 0);
    #1;
    checks++;
    if (load_use_hazard !== 1'b1) begin failures++; $display("FAIL lu_hazard_set: got %b required 1", load_use_hazard); end
    step();
    checks++;
    if ({out_valid, load_use_hazard} !== 2'b00) begin
      failures++; $display("FAIL lu_bubble: got v=%b hz=%b required v=0 hz=0", out_valid, load_use_hazard);
    end
    step();
    checks++;
    if ({out_valid, a_q, b_q, fwd_b_sel} !== {1'b1, 8'hC0, 8'hD0, 1'b0}) begin
      failures++; $display("FAIL lu_consumer: got v=%b a=%h b=%h fb=%b required v=1 a=c0 b=d0 fb=0", out_valid, a_q, b_q, fwd_b_sel);
    end
    set_instr(1, 0, 2, 2, 8'h01, 8'h02, 8'h03, 4'h5, 1, 1, 1, 0);
    step();
    set_instr(1, 1, 2, 3, 8'h04, 8'h05, 8'h06, 4'h1, 1, 1, 0, 0);
    #1;
    checks++;
    if (load_use_hazard !== 1'b0) begin failures++; $display("FAIL lu_imm_no_hazard: got %b required 0", load_use_hazard); end
    step();
    while (exp_q.size() > 0) begin
      out_t e = exp_q.pop_front();
      out_t g = got_q.pop_front();
      checks++;
      if (e.out_valid ? (g !== e) : (strip(g) !== strip(e))) begin
        failures++; $display("FAIL lu_sb: got %h required %h", g, e);
      end
    end
  endtask

  task automatic test_stall();
    out_t snap;
    set_instr(1, 2, 3, 1, 8'hA5, 8'h5A, 8'h3C, 4'h9, 0, 1, 0, 1);
    step();
    snap = sample();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(1, 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
                8'($urandom), 4'($urandom), 1'($urandom), 1, 0, 0);
      step();
      checks++;
      if (sample() !== snap) begin failures++; $display("FAIL stall_hold%0d: got %h required %h", i, sample(), snap); end
    end
    stall = 1'b0;
    set_instr(1, 0, 0, 2, 8'h10, 8'h20, 8'h30, 4'h5, 1, 1, 1, 0);
    step();
    set_instr(1, 2, 0, 1, 8'h40, 8'h50, 8'h60, 4'h1, 1, 1, 0, 0);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({load_use_hazard, out_valid, mem_rd_q, a_q} !== {3'b111, 8'h10}) begin
        failures++; $display("FAIL stall_hazard%0d: got hz=%b v=%b mr=%b a=%h required hz=1 v=1 mr=1 a=10",
                             i, load_use_hazard, out_valid, mem_rd_q, a_q);
      end
    end
    flush = 1'b1;
    step();
    checks++;
    if ({out_valid, mem_rd_q, reg_we_q, load_use_hazard} !== 4'b0000) begin
      failures++; $display("FAIL flush_stall: got v=%b mr=%b we=%b hz=%b required all 0", out_valid, mem_rd_q, reg_we_q, load_use_hazard);
    end
    flush = 1'b0; stall = 1'b0;
    while (exp_q.size() > 0) begin
      out_t e = exp_q.pop_front();
      out_t g = got_q.pop_front();
      checks++;
      if (e.out_valid ? (g !== e) : (strip(g) !== strip(e))) begin
        failures++; $display("FAIL stall_sb: got %h required %h", g, e);
      end
    end
  endtask

  task automatic test_async_reset();
    set_instr(1, 1, 2, 3, 8'hEE, 8'hDD, 8'hCC, 4'hF, 1, 1, 0, 1);
    step();
    while (exp_q.size() > 0) begin
      out_t e = exp_q.pop_front();
      out_t g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL arst_pre: got %h required %h", g, e); end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sample(), load_use_hazard} !== '0) begin
      failures++; $display("FAIL arst_immediate: got %h hz=%b required 0", sample(), load_use_hazard);
    end
    @(posedge clk); #1;
    checks++;
    if (sample() !== '0) begin failures++; $display("FAIL arst_no_capture: got %h required 0", sample()); end
    rst_n = 1'b1;
    m = '0;
    set_instr(1, 0, 1, 3, 8'h21, 8'h43, 8'h65, 4'h2, 0, 1, 1, 0);
    step();
    checks++;
    if ({out_valid, a_q, mem_rd_q} !== {1'b1, 8'h21, 1'b1}) begin
      failures++; $display("FAIL arst_first_load: got v=%b a=%h mr=%b required v=1 a=21 mr=1", out_valid, a_q, mem_rd_q);
    end
    set_instr(1, 3, 0, 0, 8'h01, 8'h02, 8'h03, 4'h1, 1, 0, 0, 0);
    stall = 1'b1;
    step();
    #2;
    checks++;
    if (load_use_hazard !== 1'b1) begin failures++; $display("FAIL arst_hz_before: got %b required 1", load_use_hazard); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({load_use_hazard, out_valid, mem_rd_q} !== 3'b000) begin
      failures++; $display("FAIL arst_mid_hazard: got hz=%b v=%b mr=%b required 0", load_use_hazard, out_valid, mem_rd_q);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; stall = 1'b0;
    m = '0;
    while (exp_q.size() > 0) begin
      out_t e = exp_q.pop_front();
      out_t g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL arst_sb: got %h required %h", g, e); end
    end
  endtask

  task automatic test_mem_conflict();
    set_instr(1, 0, 1, 2, 8'h0F, 8'hF0, 8'h08, 4'h7, 1, 0, 1, 1);
    step();
    checks++;
    if ({mem_rd_q, mem_wr_q} !== 2'b10) begin
      failures++; $display("FAIL mem_conflict: got mr=%b mw=%b required mr=1 mw=0", mem_rd_q, mem_wr_q);
    end
    set_instr(1, 3, 3, 1, 8'h1F, 8'hF1, 8'h09, 4'h8, 1, 0, 0, 1);
    step();
    checks++;
    if ({mem_rd_q, mem_wr_q} !== 2'b01) begin
      failures++; $display("FAIL mem_wr_only: got mr=%b mw=%b required mr=0 mw=1", mem_rd_q, mem_wr_q);
    end
    set_instr(0, 1, 1, 1, 8'h2F, 8'hF2, 8'h0A, 4'h9, 0, 1, 1, 1);
    step();
    checks++;
    if ({out_valid, reg_we_q, mem_rd_q, mem_wr_q} !== 4'b0000) begin
      failures++; $display("FAIL invalid_gating: got v=%b we=%b mr=%b mw=%b required all 0", out_valid, reg_we_q, mem_rd_q, mem_wr_q);
    end
    while (exp_q.size() > 0) begin
      out_t e = exp_q.pop_front();
      out_t g = got_q.pop_front();
      checks++;
      if (e.out_valid ? (g !== e) : (strip(g) !== strip(e))) begin
        failures++; $display("FAIL mem_sb: got %h required %h", g, e);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      set_instr(1'($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom), 2'($urandom),
                8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0));
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      #1;
      checks++;
      if (load_use_hazard !== model_hz(m)) begin
        failures++; $display("FAIL rand_hazard%0d: got %b required %b", i, load_use_hazard, model_hz(m));
      end
      step();
    end
    stall = 1'b0; flush = 1'b0;
    while (exp_q.size() > 0) begin
      out_t e = exp_q.pop_front();
      out_t g = got_q.pop_front();
      checks++;
      if (e.out_valid ? (g !== e) : (strip(g) !== strip(e))) begin
        failures++; $display("FAIL rand_sb: got %h required %h", g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_load_use();
    test_stall();
    test_async_reset();
    test_mem_conflict();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width.
REQ-002 SHALL have parameter RW, default 2, register-index width.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port stall  input  1  hold stage contents.
REQ-006 SHALL have port flush  input  1  replace stage contents with bubble.
REQ-007 SHALL have port in_valid  input  1  ID-stage instruction valid.
REQ-008 SHALL have ports rs_a, rs_b, rd  input  RW  source and destination register indices.
REQ-009 SHALL have ports ra_data, rb_data, imm  input  WIDTH  register-file reads and immediate.
REQ-010 SHALL have ports alu_op  input  4, plus use_imm, reg_we, mem_rd, mem_wr  input  1 each  decoded control.
REQ-011 SHALL have ports a_q, b_q, imm_q  output  WIDTH  registered operands, feeding the EX operand 2:1 muxes.
REQ-012 SHALL have ports b_sel, fwd_a_sel, fwd_b_sel  output  1  registered select lines for those muxes.
REQ-013 SHALL have ports rd_q  output  RW; alu_op_q  output  4; reg_we_q, mem_rd_q, mem_wr_q, out_valid  output  1.
REQ-014 SHALL have port load_use_hazard  output  1  combinational stall request to ID.

Function
REQ-015 SHALL resolve each clock edge in priority order: flush > stall > load_use_hazard > load.
REQ-016 On flush, SHALL capture a bubble: out_valid, reg_we_q, mem_rd_q, mem_wr_q, b_sel, fwd_a_sel and fwd_b_sel all 0; data registers may keep old values.
REQ-017 On stall without flush, SHALL hold every register unchanged.
REQ-018 On load_use_hazard without stall or flush, SHALL capture a bubble as in REQ-016.
REQ-019 On load, SHALL register all inputs with 1-cycle latency: out_valid=in_valid, b_sel=use_imm, controls gated by in_valid.
REQ-020 On load, SHALL set fwd_a_sel=1 iff in_valid & out_valid & reg_we_q & (rd_q==rs_a); the comparison uses current (pre-edge) stage contents.
REQ-021 On load, SHALL set fwd_b_sel=1 iff in_valid & !use_imm & out_valid & reg_we_q & (rd_q==rs_b).
REQ-022 SHALL compute load_use_hazard = in_valid & out_valid & mem_rd_q & ((rd_q==rs_a) | (!use_imm & rd_q==rs_b)), purely combinational.
REQ-023 SHALL ignore load_use_hazard for a captured bubble: a bubble never asserts hazard or forwarding on the next cycle.
REQ-024 With stall and load_use_hazard both high, SHALL hold (stall wins); hazard stays asserted until resolved.
REQ-025 SHALL never assert mem_rd_q and mem_wr_q together; if both are decoded, SHALL register mem_wr_q=0.
REQ-026 Index compares SHALL be full RW-bit equality; register 0 is not special.

Reset
REQ-027 On rst_n low, SHALL immediately clear all outputs and registers to 0, independent of clk.
REQ-028 On rst_n release, first load SHALL occur on the first rising clk edge with rst_n high.
REQ-029 Reset asserted mid-stall or mid-hazard SHALL discard the held instruction; load_use_hazard SHALL be 0 during reset.

Verification
REQ-030 Reset then valid ADD (rs_a=1, rs_b=2, rd=3, ra=0x12, rb=0x34): next cycle out_valid=1, a_q=0x12, b_q=0x34, b_sel=0, both fwd=0.
REQ-031 Back-to-back: rd=2/reg_we=1, then rs_a=2: second cycle fwd_a_sel=1; with use_imm=1 and rs_b=2, fwd_b_sel=0 and b_sel=1.
REQ-032 Load (mem_rd=1, rd=1), then rs_b=1, use_imm=0: load_use_hazard=1 the same cycle, bubble next cycle (out_valid=0), hazard drops, consumer loads the following cycle.
REQ-033 Stall held 3 cycles with changing inputs: all outputs hold; flush+stall together yields bubble.
REQ-034 rst_n pulsed low mid-cycle with out_valid=1: outputs 0 before next clk edge; no capture while rst_n low.
REQ-035 mem_rd=mem_wr=1 decoded: mem_rd_q=1, mem_wr_q=0.
